// File: rtl/simple_proc_ram_arbiter_if.sv
// ============================================================================
// simple_proc_ram_arbiter_if : one requester port (CPU or host) of the RAM arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface simple_proc_ram_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvld;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvld, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvld, rdata);
endinterface

`default_nettype wire

// File: rtl/simple_proc_ram_arbiter.sv
// ============================================================================
// simple_proc_ram_arbiter : CPU/host arbiter in front of the 16x128 data RAM.
// Option: SIMPLE_PROC_RAM_ARB_RR_EN selects round-robin instead of fixed priority.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module simple_proc_ram_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  simple_proc_ram_arbiter_if.slave  cpu,
  simple_proc_ram_arbiter_if.slave  host,
  output logic                      ram_read_en,
  output logic                      ram_write_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                winner_host_q, winner_host_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                host_gnt_q, host_gnt_d;
  logic                cpu_rvld_q, cpu_rvld_d;
  logic                host_rvld_q, host_rvld_d;
  logic                ram_read_en_q, ram_read_en_d;
  logic                ram_write_en_q, ram_write_en_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                host_prio;
  logic                pick_host;
  logic                sel_we;

`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
  logic                last_host_q, last_host_d;
  assign host_prio = !last_host_q;
`else
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  assign host_prio = (starve_cnt_q == 4'(STARVE_MAX));
`endif

  // host_prio only matters when both ports request
  assign pick_host = host.req && (!cpu.req || host_prio);
  assign sel_we    = pick_host ? host.we : cpu.we;

  always_comb begin
    state_d        = state_q;
    winner_host_d  = winner_host_q;
    cpu_gnt_d      = 1'b0;
    host_gnt_d     = 1'b0;
    cpu_rvld_d     = 1'b0;
    host_rvld_d    = 1'b0;
    ram_read_en_d  = 1'b0;
    ram_write_en_d = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_din_d      = ram_din_q;
`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
    last_host_d    = last_host_q;
`else
    starve_cnt_d   = starve_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu.req || host.req) begin
          state_d        = ACCESS;
          winner_host_d  = pick_host;
          cpu_gnt_d      = !pick_host;
          host_gnt_d     = pick_host;
          ram_write_en_d = sel_we;
          ram_read_en_d  = !sel_we;
          ram_addr_d     = pick_host ? host.addr  : cpu.addr;
          ram_din_d      = pick_host ? host.wdata : cpu.wdata;
`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
          last_host_d    = pick_host;
`else
          if (pick_host) begin
            starve_cnt_d = '0;
          end else if (host.req && (starve_cnt_q != 4'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
`endif
        end
      end
      ACCESS: begin
        if (ram_read_en_q) begin
          state_d     = RDATA;
          cpu_rvld_d  = !winner_host_q;
          host_rvld_d = winner_host_q;
        end else begin
          state_d     = IDLE;
        end
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      winner_host_q  <= 1'b0;
      cpu_gnt_q      <= 1'b0;
      host_gnt_q     <= 1'b0;
      cpu_rvld_q     <= 1'b0;
      host_rvld_q    <= 1'b0;
      ram_read_en_q  <= 1'b0;
      ram_write_en_q <= 1'b0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
      last_host_q    <= 1'b1;
`else
      starve_cnt_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      winner_host_q  <= winner_host_d;
      cpu_gnt_q      <= cpu_gnt_d;
      host_gnt_q     <= host_gnt_d;
      cpu_rvld_q     <= cpu_rvld_d;
      host_rvld_q    <= host_rvld_d;
      ram_read_en_q  <= ram_read_en_d;
      ram_write_en_q <= ram_write_en_d;
      ram_addr_q     <= ram_addr_d;
      ram_din_q      <= ram_din_d;
`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
      last_host_q    <= last_host_d;
`else
      starve_cnt_q   <= starve_cnt_d;
`endif
    end
  end

  assign cpu.gnt      = cpu_gnt_q;
  assign host.gnt     = host_gnt_q;
  assign cpu.rvld     = cpu_rvld_q;
  assign host.rvld    = host_rvld_q;
  // RAM output is already registered inside the RAM, so read data passes straight through
  assign cpu.rdata    = ram_dout;
  assign host.rdata   = ram_dout;
  assign ram_read_en  = ram_read_en_q;
  assign ram_write_en = ram_write_en_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_simple_proc_ram_arbiter.sv
// ============================================================================
// tb_simple_proc_ram_arbiter : randomized + directed bench against a transaction-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_simple_proc_ram_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;
  localparam int NC         = 8192;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
    int          dly;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_read_en, ram_write_en, busy;
  logic [6:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = '0;
  logic [15:0] ram_mem [128] = '{default: 16'h0};
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simple_proc_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
  simple_proc_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_if ();

  simple_proc_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu          (cpu_if),
    .host         (host_if),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .busy         (busy)
  );

  // behavioural 16x128 RAM: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_addr] <= ram_din;
    if (ram_read_en)  ram_dout <= ram_mem[ram_addr];
  end

  int tests  = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model state
  logic [6:0]  e_ctl  [NC];   // {cgnt,hgnt,re,we,crvld,hrvld,busy}
  logic [6:0]  e_addr [NC];
  logic [15:0] e_din  [NC];
  logic [15:0] e_rd   [NC];
  logic [15:0] mem_model [128] = '{default: 16'h0};
  int          next_eval;
  int          starve;
  bit          last_host;
  int          rst_at  = -1;
  bit          rst_arm = 1'b0;

  // requester drivers
  txn_t cq[$], hq[$];
  txn_t c_cur, h_cur;
  bit   c_act, h_act;
  bit   grant_log[$];

  function automatic txn_t mk(input logic we, input logic [6:0] a, input logic [15:0] d, input int dly);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.dly = dly;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we   = 1'($urandom_range(0, 1));
    t.addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
    t.data = 16'($urandom);
    t.dly  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
    return t;
  endfunction

  function automatic bit host_wins(input bit cr, input bit hr);
    if (!hr) return 1'b0;
    if (!cr) return 1'b1;
`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
    return !last_host;
`else
    return (starve == STARVE_MAX);
`endif
  endfunction

  task automatic drive_ports();
    cpu_if.req    = c_act;  cpu_if.we    = c_cur.we;
    cpu_if.addr   = c_cur.addr; cpu_if.wdata = c_cur.data;
    host_if.req   = h_act;  host_if.we   = h_cur.we;
    host_if.addr  = h_cur.addr; host_if.wdata = h_cur.data;
  endtask

  task automatic clear_model_from(input int c);
    for (int i = c; i < NC; i++) begin
      e_ctl[i] = '0; e_addr[i] = '0; e_din[i] = '0; e_rd[i] = '0;
    end
    next_eval = c;
    starve    = 0;
    last_host = 1'b1;
  endtask

  task automatic step();
    int   c;
    bit   hw;
    txn_t t;
    c = cyc;
    chk("ctl", 32'({cpu_if.gnt, host_if.gnt, ram_read_en, ram_write_en,
                    cpu_if.rvld, host_if.rvld, busy}), 32'(e_ctl[c]));
    if (e_ctl[c][4] || e_ctl[c][3]) chk("ram_addr", 32'(ram_addr), 32'(e_addr[c]));
    if (e_ctl[c][3]) chk("ram_din",    32'(ram_din),       32'(e_din[c]));
    if (e_ctl[c][2]) chk("cpu_rdata",  32'(cpu_if.rdata),  32'(e_rd[c]));
    if (e_ctl[c][1]) chk("host_rdata", 32'(host_if.rdata), 32'(e_rd[c]));
    if (cpu_if.gnt)  grant_log.push_back(1'b0);
    if (host_if.gnt) grant_log.push_back(1'b1);

    // requesters drop or replace req in the grant cycle
    if (c_act && cpu_if.gnt)  c_act = 1'b0;
    if (h_act && host_if.gnt) h_act = 1'b0;
    if (!c_act && cq.size() > 0) begin
      if (cq[0].dly > 0) cq[0].dly = cq[0].dly - 1;
      else begin c_cur = cq.pop_front(); c_act = 1'b1; end
    end
    if (!h_act && hq.size() > 0) begin
      if (hq[0].dly > 0) hq[0].dly = hq[0].dly - 1;
      else begin h_cur = hq.pop_front(); h_act = 1'b1; end
    end
    drive_ports();

    if (c >= next_eval) begin
      if (c_act || h_act) begin
        if (c + 3 >= NC) begin
          $display("FAIL cycle_budget: got %0d expected below %0d", c, NC - 3);
          $fatal(1, "cycle budget exhausted");
        end
        hw = host_wins(c_act, h_act);
        t  = hw ? h_cur : c_cur;
        e_ctl[c+1]  = {!hw, hw, !t.we, t.we, 3'b001};
        e_addr[c+1] = t.addr;
        e_din[c+1]  = t.data;
        if (t.we) begin
          mem_model[t.addr] = t.data;
          next_eval = c + 2;
        end else begin
          e_ctl[c+2] = {4'b0000, !hw, hw, 1'b1};
          e_rd[c+2]  = mem_model[t.addr];
          next_eval  = c + 3;
          if (rst_arm) begin rst_at = c + 2; rst_arm = 1'b0; end
        end
        if (hw) starve = 0;
        else if (h_act && starve < STARVE_MAX) starve++;
        last_host = hw;
      end else begin
        next_eval = c + 1;
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 32'({cpu_if.gnt, host_if.gnt, cpu_if.rvld, host_if.rvld, ram_read_en,
                  ram_write_en, busy, ram_addr, ram_din}), 32'(0));
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst_in_rdata");
    cq.delete(); hq.delete();
    c_act = 1'b0; h_act = 1'b0;
    drive_ports();
    clear_model_from(cyc);
    @(negedge clk);
    rst_n  = 1'b1;
    rst_at = -1;
    clear_model_from(cyc);
  endtask

  task automatic run(input int max);
    for (int i = 0; i < max; i++) begin
      if (rst_at == cyc + 1) mid_reset();
      @(negedge clk);
      step();
      if (cq.size() == 0 && hq.size() == 0 && !c_act && !h_act && cyc + 1 >= next_eval) break;
    end
    chk("drain", 32'(cq.size() + hq.size() + int'(c_act) + int'(h_act)), 32'(0));
  endtask

  task automatic chk_grant_order(input int n);
    bit exp_h;
    chk("grant_count", 32'(grant_log.size() >= n), 32'(1));
    for (int i = 0; i < n && i < grant_log.size(); i++) begin
`ifdef SIMPLE_PROC_RAM_ARB_RR_EN
      exp_h = (i % 2) == 1;
`else
      exp_h = (i % (STARVE_MAX + 1)) == STARVE_MAX;
`endif
      chk($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(exp_h));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    c_act = 1'b0; h_act = 1'b0;
    c_cur = mk(1'b0, 7'h0, 16'h0, 0);
    h_cur = mk(1'b0, 7'h0, 16'h0, 0);
    drive_ports();
    clear_model_from(0);
    repeat (3) @(negedge clk);
    chk_reset_outs("reset_state");
    rst_n = 1'b1;
    clear_model_from(cyc);
    step();

    // CPU write then read back
    cq.push_back(mk(1'b1, 7'h12, 16'hA5A5, 0));
    cq.push_back(mk(1'b0, 7'h12, 16'h0000, 0));
    run(50);

    // host-only write then read at the top address
    hq.push_back(mk(1'b1, 7'h7F, 16'h0001, 0));
    hq.push_back(mk(1'b0, 7'h7F, 16'h0000, 0));
    run(50);

    // both ports hammering writes
    grant_log.delete();
    for (int i = 0; i < 15; i++) begin
      cq.push_back(mk(1'b1, 7'(i), 16'($urandom), 0));
      hq.push_back(mk(1'b1, 7'(32 + i), 16'($urandom), 0));
    end
    run(200);
    chk_grant_order(15);

    // host request arrives while a CPU read is in ACCESS
    cq.push_back(mk(1'b0, 7'h12, 16'h0, 0));
    hq.push_back(mk(1'b1, 7'h30, 16'h1234, 1));
    run(50);

    // reset lands in the RDATA cycle of a CPU read
    rst_arm = 1'b1;
    hq.push_back(mk(1'b1, 7'h05, 16'h0, 3));
    cq.push_back(mk(1'b0, 7'h12, 16'h0, 0));
    run(50);

    // contested from reset: first grant must be the CPU
    grant_log.delete();
    for (int i = 0; i < 10; i++) begin
      cq.push_back(mk(1'b1, 7'(64 + i), 16'($urandom), 0));
      hq.push_back(mk(1'b1, 7'(96 + i), 16'($urandom), 0));
    end
    run(150);
    chk_grant_order(10);

    // random mixed traffic
    for (int i = 0; i < 150; i++) begin
      cq.push_back(rnd_txn());
      hq.push_back(rnd_txn());
    end
    run(4000);

    repeat (3) begin
      @(negedge clk);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
